// File: rtl/lsu_pkg.sv
// Shared types and constants for the 16-bit load/store unit.
// Holds the FSM state encoding, byte-lane selectors and the default read latency.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } lsu_state_e;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam int READ_LATENCY_DEFAULT = 1;
    localparam int CNT_W                = 2;

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte-lane extraction with sign/zero extension,
// plus byte merge into a memory word for read-modify-write stores.
module byte_lane_unit
    import lsu_pkg::*;
(
    input  logic [15:0] word_in,
    input  logic        lane,
    input  logic        sign_ext,
    input  logic [7:0]  byte_in,
    output logic [15:0] load_out,
    output logic [15:0] merge_out
);

    logic [7:0] sel;

    always_comb begin
        sel       = (lane == LANE_HI) ? word_in[15:8] : word_in[7:0];
        load_out  = {{8{sign_ext & sel[7]}}, sel};
        merge_out = (lane == LANE_HI) ? {byte_in, word_in[7:0]}
                                      : {word_in[15:8], byte_in};
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute and a 16-bit memory.
// Byte stores use read-modify-write; misaligned word accesses abort early.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = READ_LATENCY_DEFAULT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic        ReqByte,
    input  logic        ReqSigned,
    input  logic [15:0] ReqAddress,
    input  logic [15:0] ReqData,
    output logic        RespValid,
    output logic [15:0] RespData,
    output logic        RespMisaligned,
    output logic [15:0] MemByteAddress,
    output logic [15:0] MemDIN,
    output logic        MemWriteEnable,
    input  logic [15:0] MemDOUT
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    lsu_state_e       state_q, state_d;
    logic             write_q, write_d;
    logic             byte_q, byte_d;
    logic             signed_q, signed_d;
    logic             lane_q, lane_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [15:0]      resp_data_q, resp_data_d;
    logic             mis_q, mis_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      din_q, din_d;
    logic             we_q, we_d;
    logic [15:0]      load_ext;
    logic [15:0]      merged;

    byte_lane_unit u_lane (
        .word_in  (MemDOUT),
        .lane     (lane_q),
        .sign_ext (signed_q),
        .byte_in  (wbyte_q),
        .load_out (load_ext),
        .merge_out(merged)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        byte_d      = byte_q;
        signed_d    = signed_q;
        lane_d      = lane_q;
        wbyte_d     = wbyte_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        mis_d       = mis_q;
        addr_d      = addr_q;
        din_d       = din_q;
        unique case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    write_d  = ReqWrite;
                    byte_d   = ReqByte;
                    signed_d = ReqSigned;
                    lane_d   = ReqAddress[0];
                    wbyte_d  = ReqData[7:0];
                    addr_d   = {ReqAddress[15:1], 1'b0};
                    if (!ReqByte && ReqAddress[0]) begin
                        state_d     = DONE;
                        resp_data_d = '0;
                        mis_d       = 1'b1;
                    end else if (ReqWrite && !ReqByte) begin
                        state_d = WRITE;
                        din_d   = ReqData;
                    end else begin
                        state_d = READ;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            READ: begin
                // Last READ cycle: MemDOUT is valid now and is consumed directly.
                if (cnt_q == '0) begin
                    if (write_q) begin
                        state_d = WRITE;
                        din_d   = merged;
                    end else begin
                        state_d     = DONE;
                        resp_data_d = byte_q ? load_ext : MemDOUT;
                        mis_d       = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                state_d     = DONE;
                resp_data_d = '0;
                mis_d       = 1'b0;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_d == DONE);
        we_d         = (state_d == WRITE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            signed_q     <= 1'b0;
            lane_q       <= 1'b0;
            wbyte_q      <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mis_q        <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            wbyte_q      <= wbyte_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mis_q        <= mis_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            we_q         <= we_d;
        end
    end

    assign ReqReady       = ready_q;
    assign RespValid      = resp_valid_q;
    assign RespData       = resp_data_q;
    assign RespMisaligned = mis_q;
    assign MemByteAddress = addr_q;
    assign MemDIN         = din_q;
    assign MemWriteEnable = we_q;

endmodule
